// File: rtl/opf_pkg.sv
// Shared field layout for the operand-fetch issue stage.
package opf_pkg;

   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 26;
   localparam int unsigned RD_MSB  = 25;
   localparam int unsigned RD_LSB  = 21;
   localparam int unsigned RS1_MSB = 20;
   localparam int unsigned RS1_LSB = 16;
   localparam int unsigned RS2_MSB = 15;
   localparam int unsigned RS2_LSB = 11;
   localparam int unsigned IMM_MSB = 15;
   localparam int unsigned IMM_LSB = 0;

   localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;
   localparam int unsigned IMM_W   = IMM_MSB - IMM_LSB + 1;

   // opcode bit meanings: immediate form, and "no writeback"
   localparam int unsigned OPC_IMM_BIT  = 5;
   localparam int unsigned OPC_NOWB_BIT = 4;

endpackage

// File: rtl/opf_scoreboard.sv
// Pending-write scoreboard: one bit per register, r0 never pending.
module opf_scoreboard #(
   parameter int RFW = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           set_en,
   input  logic [RFW-1:0] set_idx,
   input  logic           clr_en,
   input  logic [RFW-1:0] clr_idx,
   input  logic [RFW-1:0] q_rs1,
   input  logic [RFW-1:0] q_rs2,
   input  logic [RFW-1:0] q_rd,
   output logic           pend_rs1,
   output logic           pend_rs2,
   output logic           pend_rd
);

   localparam int unsigned NREG = 2 ** RFW;

   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_nxt;

   // Clear is applied before set so a same-edge set of the same index wins.
   always_comb begin
      pend_nxt = pend;
      if (clr_en) pend_nxt[clr_idx] = 1'b0;
      if (set_en) pend_nxt[set_idx] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pend <= '0;
      else        pend <= pend_nxt;
   end

   assign pend_rs1 = pend[q_rs1];
   assign pend_rs2 = pend[q_rs2];
   assign pend_rd  = pend[q_rd];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: RF read, RAW/WAW hazard check, operand register for execute.
// Optional writeback bypass enabled by defining OPF_WB_BYPASS_EN.
module operand_fetch
   import opf_pkg::*;
#(
   parameter int RFW = 5,
   parameter int DW  = 32,
   parameter int IW  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IW-1:0]    in_instr,
   output logic [RFW-1:0]   rf_reg1,
   output logic [RFW-1:0]   rf_reg2,
   input  logic [DW-1:0]    rf_reg1data,
   input  logic [DW-1:0]    rf_reg2data,
   input  logic             wb_we,
   input  logic [RFW-1:0]   wb_reg,
   input  logic [DW-1:0]    wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OPC_W-1:0] out_opcode,
   output logic [RFW-1:0]   out_rd,
   output logic             out_rd_we,
   output logic [DW-1:0]    out_op1,
   output logic [DW-1:0]    out_op2
);

`ifdef OPF_WB_BYPASS_EN
   localparam bit WB_BYPASS = 1'b1;
`else
   localparam bit WB_BYPASS = 1'b0;
`endif

   logic [OPC_W-1:0] opcode;
   logic [RFW-1:0]   rd, rs1, rs2;
   logic [IMM_W-1:0] imm;
   logic             is_imm, rd_we;
   logic             pend_rs1, pend_rs2, pend_rd;
   logic             wb_hit1, wb_hit2, wb_clr;
   logic             haz1, haz2, haz_waw, hazard;
   logic             accept;
   logic [DW-1:0]    op1, op2;

   assign opcode = in_instr[OPC_MSB:OPC_LSB];
   assign rd     = in_instr[RD_LSB +: RFW];
   assign rs1    = in_instr[RS1_LSB +: RFW];
   assign rs2    = in_instr[RS2_LSB +: RFW];
   assign imm    = in_instr[IMM_MSB:IMM_LSB];
   assign is_imm = opcode[OPC_IMM_BIT];
   assign rd_we  = !opcode[OPC_NOWB_BIT] && (rd != '0);

   assign rf_reg1 = rs1;
   assign rf_reg2 = rs2;

   assign wb_clr  = wb_we && (wb_reg != '0);
   assign wb_hit1 = wb_we && (wb_reg == rs1) && (rs1 != '0);
   assign wb_hit2 = wb_we && (wb_reg == rs2) && (rs2 != '0);

   opf_scoreboard #(.RFW(RFW)) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (accept && rd_we),
      .set_idx  (rd),
      .clr_en   (wb_clr),
      .clr_idx  (wb_reg),
      .q_rs1    (rs1),
      .q_rs2    (rs2),
      .q_rd     (rd),
      .pend_rs1 (pend_rs1),
      .pend_rs2 (pend_rs2),
      .pend_rd  (pend_rd)
   );

   // Without bypass a source stays hazardous through its wb cycle and is
   // read from the freshly written RF one cycle later.
   assign haz1    = pend_rs1 && (rs1 != '0) && !(WB_BYPASS && wb_hit1);
   assign haz2    = !is_imm && pend_rs2 && (rs2 != '0) && !(WB_BYPASS && wb_hit2);
   assign haz_waw = rd_we && pend_rd;
   assign hazard  = haz1 || haz2 || haz_waw;

   assign in_ready = !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   assign op1 = (WB_BYPASS && wb_hit1) ? wb_data : rf_reg1data;
   assign op2 = is_imm                 ? DW'($signed(imm)) :
                (WB_BYPASS && wb_hit2) ? wb_data : rf_reg2data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_opcode <= '0;
         out_rd     <= '0;
         out_rd_we  <= 1'b0;
         out_op1    <= '0;
         out_op2    <= '0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_opcode <= opcode;
         out_rd     <= rd;
         out_rd_we  <= rd_we;
         out_op1    <= op1;
         out_op2    <= op2;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage directly upstream of the register file.
- Accepts decoded-ready instructions from fetch, drives RF read addresses, and checks RAW/WAW hazards against a pending-write scoreboard.
- Bypasses same-cycle writeback data and registers operands for the execute stage.
- Valid/ready handshake on both sides; 1-cycle latency when no hazard.

Parameters:
RFW, 5, register index width (2**RFW registers)
DW, 32, data width
IW, 32, instruction width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  fetch offers instruction
in_ready  output  1  stage accepts this cycle
in_instr  input  IW  instruction word
rf_reg1  output  RFW  RF read address 1 (= rs1 field, combinational)
rf_reg2  output  RFW  RF read address 2 (= rs2 field, combinational)
rf_reg1data  input  DW  RF read data 1 (asynchronous read, r0 returns 0)
rf_reg2data  input  DW  RF read data 2
wb_we  input  1  writeback write enable (same signal as the RF write enable)
wb_reg  input  RFW  writeback register index
wb_data  input  DW  writeback data
out_valid  output  1  operands valid to execute
out_ready  input  1  execute accepts
out_opcode  output  6  opcode
out_rd  output  RFW  destination
out_rd_we  output  1  destination write enable
out_op1  output  DW  operand 1
out_op2  output  DW  operand 2 or sign-extended immediate

Behaviour:
- Interface: one clock; reset is synchronous and active-low; clock port named clk, reset port rst_n.
- Instruction fields:
  - opcode[31:26], rd[25:21], rs1[20:16], rs2[15:11], imm[15:0].
  - opcode[5]=1: immediate form; rs2 unused; op2 = imm sign-extended to DW.
  - opcode[4]=0 and rd!=0: writes rd (rd_we=1).
- Scoreboard: 2**RFW pending bits; bit 0 is never set.
- Hazard on accepting instruction I:
  - rs1 pending, rs1!=0, and not cleared by wb this cycle; or
  - rs2 used, pending, rs2!=0, and not cleared by wb this cycle; or
  - I writes rd and rd is pending (WAW), regardless of wb.
- in_ready = !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready), on the next edge:
  - Output register loads; out_valid=1.
  - If rd_we, pending[rd] is set.
- wb_we with wb_reg!=0 clears pending[wb_reg] at the edge.
  - Same-edge set and clear of the same index: set wins.
- Bypass: if wb_we && wb_reg==rsX && rsX!=0, operand X takes wb_data instead of rf data.
- out_valid && !out_ready: all out_* held stable; no new accept.
- out_valid drops when out_ready && !accept.
- Reset:
  - out_valid=0, in_ready follows its equation, scoreboard all 0.
  - out_opcode/out_rd/out_op1/out_op2=0, out_rd_we=0.
  - Reset mid-stall discards the held entry and all pending bits.
- in_ready may depend combinationally on in_instr; in_valid must not depend on in_ready.

Optional Feature:
- Macro OPF_WB_BYPASS_EN.
- Defined:
  - Bypass as above.
  - A source whose pending bit is cleared by wb this cycle is not a hazard.
- Undefined:
  - No bypass; operands always come from the RF.
  - A pending source stalls through the wb cycle and issues the cycle after, reading the now-written RF.

Decomposition:
- Shared package opf_pkg:
  - Field bit positions: OPC_MSB/LSB, RD_MSB/LSB, RS1_MSB/LSB, RS2_MSB/LSB, IMM_MSB/LSB.
  - OPC_IMM_BIT=5 and OPC_NOWB_BIT=4.
- One sub-module: opf_scoreboard.
  - Holds the pending bits with set/clear ports.
  - Three combinational query ports (rs1, rs2, rd) returning pending status.

Test Plan:
- Reset, then in_valid with rs1=3, rs2=4 (RF r3=7, r4=9), opcode 0x00, rd=5 -> next cycle out_valid=1, op1=7, op2=9, out_rd_we=1, pending[5]=1.
- Immediate form opcode 0x20, imm=0xFFFE -> op2=0xFFFFFFFE; rs2 field not hazard-checked.
- Issue rd=5, then a reader of r5 with no wb -> in_ready=0 each cycle. Then wb_we=1, wb_reg=5, wb_data=0x55:
  - With bypass: accept that cycle, op1=0x55.
  - Without bypass: accept one cycle later.
- out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0. out_ready=1 -> pending instruction accepted the same cycle.
- rs1=0, rd=0 -> op1=0, no scoreboard set, no stall. Same-edge accept rd=6 with wb clearing r6 -> pending[6]=1 afterwards.
- rst_n=0 while stalled on pending r5 -> out_valid=0 and scoreboard cleared the next edge; a reader of r5 issues immediately after reset.
